bcd_seg7_mux: RTL and testbench
===============================

// Module: bcd_seg7_mux
// PURPOSE
//   Display stage downstream of the binary-to-decimal converter. Captures the
//   tens/ones BCD pair when the converter signals ready, then drives a 2-digit
//   multiplexed 7-segment display (shared segment bus, one enable per digit).
//   Provides refresh timing, anti-ghosting dead time, leading-zero blanking and
//   an invalid-digit indication.
// PARAMETERS
//   REFRESH_DIV  1000  clock cycles per digit slot (>=2)
//   CNT_W        10    refresh counter width; must satisfy 2**CNT_W >= REFRESH_DIV
//   ACTIVE_LOW   0     0: seg_o/dig_o active-high; 1: both physically inverted
// PORTS
//   clk_i       in   1  system clock
//   rst_i       in   1  asynchronous reset, active-high
//   tens_i      in   4  BCD tens digit from converter
//   ones_i      in   4  BCD ones digit from converter
//   valid_i     in   1  capture strobe (converter ready); sampled every cycle
//   blank_lz_i  in   1  1: blank the tens digit when it is 0
//   seg_o       out  7  segments {g,f,e,d,c,b,a}
//   dig_o       out  2  digit enables; [0]=ones, [1]=tens
// BEHAVIOUR
//   Reset (async, immediate): tens_q=0, ones_q=0, have_data=0, cnt=0, sel=0
//     (ones slot); seg_o and dig_o at inactive level (0 when ACTIVE_LOW=0,
//     all-ones when ACTIVE_LOW=1). Applies mid-slot/mid-capture too.
//   Capture: at a clock edge with valid_i=1: tens_q<=tens_i, ones_q<=ones_i,
//     have_data<=1. valid_i held high recaptures every cycle; no backpressure.
//   Refresh: cnt counts 0..REFRESH_DIV-1; at REFRESH_DIV-1 it wraps to 0 and
//     sel toggles (ones -> tens -> ones ...). Full frame = 2*REFRESH_DIV cycles.
//   Output regs (1-cycle latency from cnt/sel/tens_q/ones_q):
//     - dead time: when cnt==0 both dig_o inactive (seg_o still driven).
//     - have_data=0: both dig_o inactive, seg_o inactive (display dark).
//     - sel=0: seg_o=decode(ones_q), dig_o[0] active.
//     - sel=1: seg_o=decode(tens_q), dig_o[1] active, unless blank_lz_i=1 and
//       tens_q==0 -> dig_o both inactive, seg_o inactive. Ones never blanked.
//   Decode (active-high, gfedcba hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D
//     7=07 8=7F 9=6F; codes 10..15 -> 40 (dash, segment g only).
//   ACTIVE_LOW=1: seg_o and dig_o are bitwise inverted at output; logic same.
//   Simultaneous valid_i and slot switch: both take effect on the same edge;
//     the new slot displays the new value one cycle later (no stale mix
//     beyond that single cycle, which falls in dead time).
//   Value change mid-slot: visible from the next cycle; slot timing unaffected.
//   No combinational input-to-output paths; all outputs registered.
// TESTING (ACTIVE_LOW=0, REFRESH_DIV=4 unless stated)
//   1 Assert rst_i, release, no valid_i for 20 cycles -> seg_o=00, dig_o=00
//     throughout; cnt/sel still run (observe via later timing).
//   2 valid_i pulse tens=4 ones=2 -> ones slot: dig_o=01 seg_o=5B; tens slot:
//     dig_o=10 seg_o=66; each slot shows 3 active cycles after 1 dead cycle,
//     slot period exactly 4 cycles.
//   3 tens=0 ones=7, blank_lz_i=1 -> tens slot dig_o=00; blank_lz_i=0 ->
//     tens slot dig_o=10 seg_o=3F; ones slot seg_o=07 in both cases.
//   4 tens=12 ones=15 -> seg_o=40 in both slots; tens=9 ones=9 -> 6F/6F.
//   5 ACTIVE_LOW=1, tens=8 ones=1 -> ones slot seg_o=79 dig_o=10; reset ->
//     seg_o=7F dig_o=11.
//   6 Assert rst_i asynchronously mid-slot with data 5/3 -> outputs go
//     inactive without a clock edge; after release display dark until next
//     valid_i; first refresh slot after reset is ones.

Source files
------------

// File: rtl/bcd_seg7_mux.sv
// Two-digit multiplexed 7-segment driver: captures a BCD tens/ones pair on
// valid_i and time-multiplexes it onto a shared segment bus with dead time.
module bcd_seg7_mux #(
  parameter int unsigned REFRESH_DIV = 1000,
  parameter int unsigned CNT_W       = 10,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] tens_i,
  input  logic [3:0] ones_i,
  input  logic       valid_i,
  input  logic       blank_lz_i,
  output logic [6:0] seg_o,
  output logic [1:0] dig_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]       SEG_POL = {7{ACTIVE_LOW}};
  localparam logic [1:0]       DIG_POL = {2{ACTIVE_LOW}};

  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic             have_q, have_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       dig_q, dig_d;

  // Active-high gfedcba decode; non-BCD codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  always_comb begin
    logic [6:0] seg_act;
    logic [1:0] dig_act;
    tens_d  = tens_q;
    ones_d  = ones_q;
    have_d  = have_q;
    cnt_d   = cnt_q + CNT_W'(1);
    sel_d   = sel_q;
    seg_act = 7'h00;
    dig_act = 2'b00;

    if (valid_i) begin
      tens_d = tens_i;
      ones_d = ones_i;
      have_d = 1'b1;
    end

    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      sel_d = ~sel_q;
    end

    // Display content from current state; cnt==0 is the anti-ghosting gap.
    if (have_q) begin
      if (!sel_q) begin
        seg_act = decode(ones_q);
        dig_act = 2'b01;
      end else if (!(blank_lz_i && (tens_q == 4'd0))) begin
        seg_act = decode(tens_q);
        dig_act = 2'b10;
      end
      if (cnt_q == '0) dig_act = 2'b00;
    end

    seg_d = seg_act ^ SEG_POL;
    dig_d = dig_act ^ DIG_POL;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
      have_q <= 1'b0;
      cnt_q  <= '0;
      sel_q  <= 1'b0;
      seg_q  <= SEG_POL;
      dig_q  <= DIG_POL;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
      have_q <= have_d;
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      seg_q  <= seg_d;
      dig_q  <= dig_d;
    end
  end

  assign seg_o = seg_q;
  assign dig_o = dig_q;

endmodule

// File: tb/tb_bcd_seg7_mux.sv
// Bench for bcd_seg7_mux: an active-high and an active-low instance share
// stimulus and are checked every cycle against a time-based display model.
module tb_bcd_seg7_mux;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] tens = 4'd0;
  logic [3:0] ones = 4'd0;
  logic       valid = 1'b0;
  logic       blank = 1'b0;
  logic [6:0] seg_h, seg_l;
  logic [1:0] dig_h, dig_l;

  int errors = 0;
  int checks = 0;

  // Model: edges since reset, plus the last captured pair.
  int         m_e = 0;
  logic [3:0] m_tens = 4'd0;
  logic [3:0] m_ones = 4'd0;
  logic       m_have = 1'b0;

  logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  bcd_seg7_mux #(.REFRESH_DIV(DIV), .CNT_W(2), .ACTIVE_LOW(1'b0)) dut_h (
    .clk_i(clk), .rst_i(rst), .tens_i(tens), .ones_i(ones), .valid_i(valid),
    .blank_lz_i(blank), .seg_o(seg_h), .dig_o(dig_h));

  bcd_seg7_mux #(.REFRESH_DIV(DIV), .CNT_W(2), .ACTIVE_LOW(1'b1)) dut_l (
    .clk_i(clk), .rst_i(rst), .tens_i(tens), .ones_i(ones), .valid_i(valid),
    .blank_lz_i(blank), .seg_o(seg_l), .dig_o(dig_l));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected {dig,seg} (active-high) after the edge that follows e earlier edges.
  function automatic logic [8:0] expect_out(input int e, input logic [3:0] t,
                                            input logic [3:0] o, input logic have,
                                            input logic blk);
    int  pos;
    bit  tens_slot;
    logic [1:0] d;
    pos       = e % DIV;
    tens_slot = ((e / DIV) % 2) == 1;
    if (!have) return 9'h000;
    if (tens_slot && blk && t == 4'd0) return 9'h000;
    d = tens_slot ? 2'b10 : 2'b01;
    if (pos == 0) d = 2'b00;
    return {d, tens_slot ? dec_tab[t] : dec_tab[o]};
  endfunction

  task automatic check_all(input logic [8:0] exp);
    check("seg_hi", {1'b0, seg_h}, {1'b0, exp[6:0]});
    check("dig_hi", {6'd0, dig_h}, {6'd0, exp[8:7]});
    check("seg_lo", {1'b0, seg_l}, {1'b0, ~exp[6:0]});
    check("dig_lo", {6'd0, dig_l}, {6'd0, ~exp[8:7]});
  endtask

  // One clock: predict from pre-edge state and inputs, advance model, compare.
  task automatic cycle();
    logic [8:0] exp;
    exp = expect_out(m_e, m_tens, m_ones, m_have, blank);
    @(posedge clk);
    if (valid) begin
      m_tens = tens;
      m_ones = ones;
      m_have = 1'b1;
    end
    m_e++;
    #1;
    check_all(exp);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load(input logic [3:0] t, input logic [3:0] o);
    tens  = t;
    ones  = o;
    valid = 1'b1;
    cycle();
    valid = 1'b0;
  endtask

  task automatic model_reset();
    m_e    = 0;
    m_tens = 4'd0;
    m_ones = 4'd0;
    m_have = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_seg_hi", {1'b0, seg_h}, 8'h00);
    check("rst_dig_hi", {6'd0, dig_h}, 8'h00);
    check("rst_seg_lo", {1'b0, seg_l}, 8'h7F);
    check("rst_dig_lo", {6'd0, dig_l}, 8'h03);
    rst = 1'b0;
    model_reset();

    // Dark with no data
    run(20);

    // 4/2 through several full frames
    load(4'd4, 4'd2);
    run(17);

    // Leading-zero blanking on and off
    blank = 1'b1;
    load(4'd0, 4'd7);
    run(16);
    blank = 1'b0;
    run(16);

    // Invalid codes and 9/9
    load(4'd12, 4'd15);
    run(10);
    load(4'd9, 4'd9);
    run(10);

    // Active-low values for 8/1 are checked via the inverted instance
    load(4'd8, 4'd1);
    run(9);

    // Async reset mid-slot with 5/3 loaded
    load(4'd5, 4'd3);
    run(6);
    #2 rst = 1'b1;
    #1;
    check("arst_seg_hi", {1'b0, seg_h}, 8'h00);
    check("arst_dig_hi", {6'd0, dig_h}, 8'h00);
    check("arst_seg_lo", {1'b0, seg_l}, 8'h7F);
    check("arst_dig_lo", {6'd0, dig_l}, 8'h03);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run(10);
    load(4'd6, 4'd3);
    run(12);

    // Random traffic: sparse and held valid, mid-slot changes, blank toggling
    for (int i = 0; i < 400; i++) begin
      tens  = 4'($urandom_range(0, 15));
      ones  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) tens = 4'd0;
      valid = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) blank = ~blank;
      cycle();
    end
    valid = 1'b0;
    run(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
